cache_ri: RTL

- Line refill / write-back engine of the cache.
- On a miss from the cache control logic it optionally writes the dirty victim line back to memory as one burst write. It then fetches the new line as one burst read and writes it word-by-word into the cache data RAM.
- Its bus master port connects to the s1 slave port of cache_arb, which forwards it to the system bus.

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_ri.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: the refill-engine state encoding and constants used by
// the cache top, the tag RAM and the refill engine.
package cache_pkg;

  localparam int unsigned DEFAULT_LINE_WORDS = 8;
  localparam logic [3:0]  BYTE_EN_FULL       = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StWbPrime,
    StWbBurst,
    StRfCmd,
    StRfData,
    StDone
  } cache_ri_state_t;

endpackage

// File: rtl/cache_ri.sv
// Line refill / write-back engine: optional dirty-victim burst write, then burst refill
// into the data RAM. Define CACHE_RI_FWD_EN to add critical-word forwarding.
module cache_ri
  import cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int unsigned OFS_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             ri_req,
  input  logic             ri_dirty,
  input  logic [31:0]      ri_wbAddr,
  input  logic [31:0]      ri_refillAddr,
  output logic             ri_busy,
  output logic             ri_done,
  output logic [OFS_W-1:0] ram_rdOffset,
  input  logic [31:0]      ram_readData,
  output logic             ram_write,
  output logic [OFS_W-1:0] ram_wrOffset,
  output logic [31:0]      ram_writeData,
  output logic [31:0]      m_address,
  output logic [3:0]       m_byteEnable,
  output logic             m_read,
  output logic             m_write,
  output logic [31:0]      m_writeData,
  input  logic             m_waitRequest,
  input  logic [31:0]      m_readData,
  input  logic             m_readDataValid,
  output logic             m_beginBurstTransfer,
  output logic [7:0]       m_burstCount
`ifdef CACHE_RI_FWD_EN
  ,
  input  logic [OFS_W-1:0] ri_critOffset,
  output logic             fwd_valid,
  output logic [31:0]      fwd_data
`endif
);

  localparam int unsigned    ALIGN_W   = OFS_W + 2;
  localparam logic [31:0]    ADDR_MASK = ~((32'd1 << ALIGN_W) - 32'd1);
  localparam logic [OFS_W:0] CNT_LAST  = (OFS_W+1)'(LINE_WORDS - 1);
  localparam logic [7:0]     BURST_LEN = 8'(LINE_WORDS);

  cache_ri_state_t state_q, state_d;
  logic [OFS_W:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0]     wb_addr_q, rf_addr_q;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wb_addr_q <= '0;
      rf_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && ri_req) begin
        wb_addr_q <= ri_wbAddr & ADDR_MASK;
        rf_addr_q <= ri_refillAddr & ADDR_MASK;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    cnt_inc              = cnt_q + 1'b1;
    ri_busy              = (state_q != StIdle);
    ri_done              = 1'b0;
    ram_rdOffset         = '0;
    ram_write            = 1'b0;
    ram_wrOffset         = '0;
    ram_writeData        = '0;
    m_address            = '0;
    m_byteEnable         = '0;
    m_read               = 1'b0;
    m_write              = 1'b0;
    m_writeData          = '0;
    m_beginBurstTransfer = 1'b0;
    m_burstCount         = '0;

    unique case (state_q)
      StIdle: begin
        if (ri_req) state_d = ri_dirty ? StWbPrime : StRfCmd;
      end
      StWbPrime: begin
        cnt_d   = '0;
        state_d = StWbBurst;
      end
      StWbBurst: begin
        m_write              = 1'b1;
        m_address            = wb_addr_q;
        m_byteEnable         = BYTE_EN_FULL;
        m_burstCount         = BURST_LEN;
        m_writeData          = ram_readData;
        m_beginBurstTransfer = (cnt_q == '0);
        // Keep the RAM one word ahead of the bus: re-read on stall, advance on accept.
        ram_rdOffset         = cnt_q[OFS_W-1:0];
        if (!m_waitRequest) begin
          ram_rdOffset = cnt_inc[OFS_W-1:0];
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = StRfCmd;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StRfCmd: begin
        m_read               = 1'b1;
        m_address            = rf_addr_q;
        m_byteEnable         = BYTE_EN_FULL;
        m_burstCount         = BURST_LEN;
        m_beginBurstTransfer = 1'b1;
        if (!m_waitRequest) begin
          cnt_d   = '0;
          state_d = StRfData;
        end
      end
      StRfData: begin
        if (m_readDataValid) begin
          ram_write     = 1'b1;
          ram_wrOffset  = cnt_q[OFS_W-1:0];
          ram_writeData = m_readData;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDone: begin
        ri_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CACHE_RI_FWD_EN
  logic [OFS_W-1:0] crit_q;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      crit_q <= '0;
    end else if (state_q == StIdle && ri_req) begin
      crit_q <= ri_critOffset;
    end
  end

  // Bypass the critical word straight from the bus so the CPU can restart early.
  always_comb begin
    fwd_valid = (state_q == StRfData) && m_readDataValid && (cnt_q == {1'b0, crit_q});
    fwd_data  = fwd_valid ? m_readData : '0;
  end
`endif

endmodule
